// File: rtl/sequence_generator.sv
`default_nettype none
// ============================================================================
// Module   : sequence_generator
// Brief    : Captures an 8-bit switch value on a button press and shifts it
//            out LSB first, with optional even parity, BIT_CYCLES per bit.
// Revision : 1.0 - initial release
// ============================================================================
module sequence_generator #(
    parameter int BIT_CYCLES = 1,
    parameter int PARITY_EN  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic [7:0] switch,
    output logic       serial_out,
    output logic       bit_valid,
    output logic [3:0] bit_index,
    output logic       busy,
    output logic       done,
    output logic       led
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_BIT = (PARITY_EN != 0) ? 4'd8 : 4'd7;
    localparam logic [7:0] c_DIV_LAST = 8'(BIT_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_shift;
    logic [7:0] r_div;
    logic [3:0] r_bit;
    logic       r_parity;
    logic       r_led;
    logic       w_legal;

    assign w_legal = (r_state == IDLE) || (r_state == SEND) || (r_state == DONE);

    // A button press restarts the frame from any legal state, so the capture
    // path is shared ahead of the per-state behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= 8'd0;
            r_div    <= 8'd0;
            r_bit    <= 4'd0;
            r_parity <= 1'b0;
            r_led    <= 1'b0;
        end else begin
            if (button) begin
                r_led <= 1'b0;
            end
            if (!w_legal) begin
                r_state <= IDLE;
            end else if (button) begin
                r_shift  <= switch;
                r_bit    <= 4'd0;
                r_div    <= 8'd0;
                r_parity <= ^switch;
                r_state  <= SEND;
            end else begin
                case (r_state)
                    SEND: begin
                        if (r_div == c_DIV_LAST) begin
                            r_div   <= 8'd0;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 4'd1;
                            if (r_bit == c_LAST_BIT) begin
                                r_state <= DONE;
                                r_led   <= 1'b1;
                            end
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    // The data bits are exhausted by the time index 8 is reached, so the
    // parity bit comes from its own register.
    assign serial_out = (r_state == SEND) &&
                        ((r_bit == 4'd8) ? r_parity : r_shift[0]);
    assign bit_valid  = (r_state == SEND) && (r_div == 8'd0);
    assign bit_index  = (r_state == SEND) ? r_bit : 4'd0;
    assign busy       = (r_state == SEND);
    assign done       = (r_state == DONE);
    assign led        = r_led;

endmodule
`default_nettype wire

// File: tb/tb_sequence_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequence_generator
// Brief    : Directed table-driven bench for sequence_generator in two
//            configurations (1 cycle/bit no parity, 3 cycles/bit with parity).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sequence_generator;

    logic       clk;
    logic       rst;
    logic       button;
    logic [7:0] switch;

    logic       a_ser, a_bv, a_busy, a_done, a_led;
    logic [3:0] a_idx;
    logic       b_ser, b_bv, b_busy, b_done, b_led;
    logic [3:0] b_idx;

    int n_checks;
    int n_fail;

    sequence_generator #(.BIT_CYCLES(1), .PARITY_EN(0)) u_dut_a (
        .clk(clk), .rst(rst), .button(button), .switch(switch),
        .serial_out(a_ser), .bit_valid(a_bv), .bit_index(a_idx),
        .busy(a_busy), .done(a_done), .led(a_led)
    );

    sequence_generator #(.BIT_CYCLES(3), .PARITY_EN(1)) u_dut_b (
        .clk(clk), .rst(rst), .button(button), .switch(switch),
        .serial_out(b_ser), .bit_valid(b_bv), .bit_index(b_idx),
        .busy(b_busy), .done(b_done), .led(b_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       btn;
        logic [7:0] sw;
        logic [8:0] exp;
    } vec_t;

    // Packed layout: {serial_out, bit_valid, bit_index[3:0], busy, done, led}
    function automatic logic [8:0] pk(input logic ser, input logic bv,
                                      input logic [3:0] idx, input logic bsy,
                                      input logic dn, input logic ld);
        return {ser, bv, idx, bsy, dn, ld};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string name, input logic [8:0] exp);
        chk(name, 32'({a_ser, a_bv, a_idx, a_busy, a_done, a_led}), 32'(exp));
    endtask

    task automatic chk_b(input string name, input logic [8:0] exp);
        chk(name, 32'({b_ser, b_bv, b_idx, b_busy, b_done, b_led}), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        button = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    vec_t       vecs[10];
    logic [7:0] pat;
    int         done_cnt;
    int         done_at;
    logic       bit_exp;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        button   = 1'b0;
        switch   = 8'h00;
        #3;
        chk_a("reset_a", pk(0, 0, 4'd0, 0, 0, 0));
        chk_b("reset_b", pk(0, 0, 4'd0, 0, 0, 0));

        // Button held during reset is ignored; capture on first edge after release.
        button = 1'b1;
        switch = 8'h35;
        tick();
        tick();
        chk_a("btn_in_rst", pk(0, 0, 4'd0, 0, 0, 0));
        rst = 1'b0;
        tick();
        chk_a("first_capture", pk(1, 1, 4'd0, 1, 0, 0));

        // Basic frame 8'h35, one cycle per bit.
        vecs[0] = '{1'b1, 8'h35, pk(1, 1, 4'd0, 1, 0, 0)};
        vecs[1] = '{1'b0, 8'h00, pk(0, 1, 4'd1, 1, 0, 0)};
        vecs[2] = '{1'b0, 8'h00, pk(1, 1, 4'd2, 1, 0, 0)};
        vecs[3] = '{1'b0, 8'h00, pk(0, 1, 4'd3, 1, 0, 0)};
        vecs[4] = '{1'b0, 8'h00, pk(1, 1, 4'd4, 1, 0, 0)};
        vecs[5] = '{1'b0, 8'h00, pk(1, 1, 4'd5, 1, 0, 0)};
        vecs[6] = '{1'b0, 8'h00, pk(0, 1, 4'd6, 1, 0, 0)};
        vecs[7] = '{1'b0, 8'h00, pk(0, 1, 4'd7, 1, 0, 0)};
        vecs[8] = '{1'b0, 8'h00, pk(0, 0, 4'd0, 0, 1, 1)};
        vecs[9] = '{1'b0, 8'h00, pk(0, 0, 4'd0, 0, 0, 1)};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            button = vecs[i].btn;
            switch = vecs[i].sw;
            tick();
            chk_a($sformatf("vec35_cycle%0d", i + 1), vecs[i].exp);
        end

        // Three cycles per bit with parity, 8'h07 -> parity bit 1.
        do_reset();
        pat    = 8'h07;
        button = 1'b1;
        switch = pat;
        tick();
        button = 1'b0;
        for (int c = 0; c < 27; c++) begin
            bit_exp = (c / 3 < 8) ? pat[c / 3] : 1'b1;
            chk_b($sformatf("par_cycle%0d", c + 1),
                  pk(bit_exp, (c % 3) == 0, 4'(c / 3), 1, 0, 0));
            tick();
        end
        chk_b("par_done", pk(0, 0, 4'd0, 0, 1, 1));
        tick();
        chk_b("par_idle", pk(0, 0, 4'd0, 0, 0, 1));

        // Abort at bit 4 with new data 8'h00.
        do_reset();
        button = 1'b1;
        switch = 8'hFF;
        tick();
        button = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk_a("abort_pre", pk(1, 1, 4'd4, 1, 0, 0));
        button = 1'b1;
        switch = 8'h00;
        tick();
        button = 1'b0;
        chk_a("abort_restart", pk(0, 1, 4'd0, 1, 0, 0));
        done_cnt = 0;
        done_at  = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (a_done) begin
                done_cnt++;
                done_at = t;
            end
        end
        chk("abort_done_count", 32'(done_cnt), 32'd1);
        chk("abort_done_at", 32'(done_at), 32'd8);

        // Reset mid-frame at bit 5 of 8'hA5.
        do_reset();
        pat    = 8'hA5;
        button = 1'b1;
        switch = pat;
        tick();
        button = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_a("rst_mid_pre", pk(1, 1, 4'd5, 1, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        chk_a("rst_mid_async", pk(0, 0, 4'd0, 0, 0, 0));
        tick();
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_done || a_busy) done_cnt++;
        end
        chk("rst_mid_quiet", 32'(done_cnt), 32'd0);
        button = 1'b1;
        tick();
        button = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_a($sformatf("rst_refr_bit%0d", i), pk(pat[i], 1, 4'(i), 1, 0, 0));
            tick();
        end
        chk_a("rst_refr_done", pk(0, 0, 4'd0, 0, 1, 1));

        // Button held 5 cycles keeps restarting at bit 0.
        do_reset();
        pat    = 8'h35;
        switch = pat;
        button = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_a($sformatf("hold_cycle%0d", i), pk(1, 1, 4'd0, 1, 0, 0));
        end
        button = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_a($sformatf("hold_bit%0d", i), pk(pat[i], 1, 4'(i), 1, 0, 0));
        end
        tick();
        chk_a("hold_done", pk(0, 0, 4'd0, 0, 1, 1));

        // Sticky led across idle cycles, cleared by the next button.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_a($sformatf("led_hold%0d", i), pk(0, 0, 4'd0, 0, 0, 1));
        end
        button = 1'b1;
        switch = 8'h01;
        tick();
        button = 1'b0;
        chk_a("led_clear", pk(1, 1, 4'd0, 1, 0, 0));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
